syscall_halt_ctrl: RTL and testbench

Sequential syscall/halt controller for the single-cycle MIPS core. It replaces the purely combinational PC-enable term with a state machine.
- Decodes the syscall service code in $v0.
- Latches $a0 for the display on print syscalls.
- Holds the PC on pause/exit syscalls; pause resumes on a clean, synchronised rising edge of the Go button.
- Keeps saturating event counters for the board display.

---
 rtl/syscall_halt_ctrl.sv | 120 ++++++++++++
 tb/tb_syscall_halt_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_halt_ctrl.sv
// Syscall/halt controller: decodes $v0, latches $a0 on print, holds the PC on pause/exit.
// pc_en is combinational; go resumes pause SYNC_STAGES edges after it rises; no backpressure.
module syscall_halt_ctrl #(
    parameter int DATA_W      = 32,
    parameter int PRINT_CODE  = 34,
    parameter int EXIT_CODE   = 10,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              syscall,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    input  logic              go,
    output logic              pc_en,
    output logic              halted,
    output logic              exited,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [CNT_W-1:0]  halt_cnt,
    output logic [CNT_W-1:0]  print_cnt
);

    typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_EXIT} state_e;

    localparam logic [DATA_W-1:0] PRINT_V = DATA_W'(PRINT_CODE);
    localparam logic [DATA_W-1:0] EXIT_V  = DATA_W'(EXIT_CODE);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   go_q, go_d;
    logic [DATA_W-1:0]      disp_data_q, disp_data_d;
    logic                   disp_valid_q, disp_valid_d;
    logic [CNT_W-1:0]       halt_cnt_q, halt_cnt_d;
    logic [CNT_W-1:0]       print_cnt_q, print_cnt_d;
    logic                   halted_q, halted_d;
    logic                   exited_q, exited_d;

    logic is_print, is_exit, run_pc_en, go_rise;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], go};
        go_d         = sync_q[SYNC_STAGES-1];
        go_rise      = sync_q[SYNC_STAGES-1] & ~go_q;
        is_print     = (v0 == PRINT_V);
        is_exit      = (v0 == EXIT_V);
        run_pc_en    = ~syscall | is_print;

        state_d      = state_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        halt_cnt_d   = halt_cnt_q;
        print_cnt_d  = print_cnt_q;
        pc_en        = 1'b0;

        case (state_q)
            ST_RUN: begin
                pc_en = run_pc_en;
                if (syscall) begin
                    if (is_print) begin
                        disp_data_d  = a0;
                        disp_valid_d = 1'b1;
                        print_cnt_d  = (print_cnt_q == CNT_MAX) ? print_cnt_q
                                                                : print_cnt_q + CNT_W'(1);
                    end else begin
                        state_d    = is_exit ? ST_EXIT : ST_PAUSE;
                        halt_cnt_d = (halt_cnt_q == CNT_MAX) ? halt_cnt_q
                                                             : halt_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                // The PC steps past the held syscall in exactly the resume cycle.
                pc_en = go_rise;
                if (go_rise) state_d = ST_RUN;
            end
            ST_EXIT: pc_en = 1'b0;
            default: state_d = ST_RUN;
        endcase

        if (rst) pc_en = run_pc_en;

        halted_d = (state_d != ST_RUN);
        exited_d = (state_d == ST_EXIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            sync_q       <= '0;
            go_q         <= 1'b0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            halt_cnt_q   <= '0;
            print_cnt_q  <= '0;
            halted_q     <= 1'b0;
            exited_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            go_q         <= go_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            halt_cnt_q   <= halt_cnt_d;
            print_cnt_q  <= print_cnt_d;
            halted_q     <= halted_d;
            exited_q     <= exited_d;
        end
    end

    assign halted     = halted_q;
    assign exited     = exited_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign halt_cnt   = halt_cnt_q;
    assign print_cnt  = print_cnt_q;

endmodule

// File: tb/tb_syscall_halt_ctrl.sv
// Bench for syscall_halt_ctrl: scenario tasks with inline checks, printed values tracked in a queue.
module tb_syscall_halt_ctrl;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst, syscall, go;
    logic [31:0] v0, a0;
    logic        pc_en, halted, exited, disp_valid;
    logic [31:0] disp_data;
    logic [15:0] halt_cnt, print_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    syscall_halt_ctrl #(
        .DATA_W(32), .PRINT_CODE(34), .EXIT_CODE(10), .SYNC_STAGES(S), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0), .go(go),
        .pc_en(pc_en), .halted(halted), .exited(exited),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .halt_cnt(halt_cnt), .print_cnt(print_cnt)
    );

    // Every disp_valid pulse must retire the oldest outstanding print.
    always @(negedge clk) begin
        if (disp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL disp_unexpected: disp_valid=1 disp_data=%h, none pending", disp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (disp_data !== mon_exp) begin
                    failures++;
                    $display("FAIL disp_data: got=%h exp=%h", disp_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) next();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL reset_pc_en cyc=%0d got=%b exp=1", i, pc_en); end
            checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted cyc=%0d got=%b exp=0", i, halted); end
            checks++; if (exited !== 1'b0) begin failures++; $display("FAIL reset_exited cyc=%0d got=%b exp=0", i, exited); end
            checks++; if (halt_cnt !== 16'd0) begin failures++; $display("FAIL reset_halt_cnt got=%0d exp=0", halt_cnt); end
            checks++; if (print_cnt !== 16'd0) begin failures++; $display("FAIL reset_print_cnt got=%0d exp=0", print_cnt); end
            checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); end
            checks++; if (disp_data !== 32'd0) begin failures++; $display("FAIL reset_disp_data got=%h exp=0", disp_data); end
            next();
        end
    endtask

    task automatic test_print();
        syscall = 1'b1; v0 = 32'd34; a0 = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL print_pc_en got=%b exp=1", pc_en); end
        next();
        syscall = 1'b0; a0 = 32'h0;
        @(negedge clk);
        checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL print_valid got=%b exp=1", disp_valid); end
        checks++; if (print_cnt !== 16'd1) begin failures++; $display("FAIL print_cnt got=%0d exp=1", print_cnt); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL print_halted got=%b exp=0", halted); end
        next();
        @(negedge clk);
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL print_valid_pulse got=%b exp=0", disp_valid); end
        checks++; if (disp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL print_hold got=%h exp=deadbeef", disp_data); end
        next();
    endtask

    // Leaves PAUSE with a clean go edge; go is returned low and its chain drained.
    task automatic release_pause();
        bit done;
        syscall = 1'b0; go = 1'b0;
        repeat (S + 2) next();
        go = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (halted === 1'b0) done = 1'b1;
            next();
        end
        checks++; if (!done) begin failures++; $display("FAIL release_timeout: halted=%b exp=0 within 10 cycles", halted); end
        go = 1'b0;
        repeat (S + 2) next();
    endtask

    task automatic test_pause();
        syscall = 1'b1; v0 = 32'd5; go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL pause_pc_en cyc=%0d got=%b exp=0", i, pc_en); end
            checks++; if (halted !== (i != 0)) begin failures++; $display("FAIL pause_halted cyc=%0d got=%b exp=%b", i, halted, i != 0); end
            if (i > 0) begin
                checks++; if (halt_cnt !== 16'd1) begin failures++; $display("FAIL pause_halt_cnt cyc=%0d got=%0d exp=1", i, halt_cnt); end
            end
            next();
        end
        // go raised in cycle 1; syscall stays held so the core re-pauses right after resuming.
        go = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++; if (pc_en !== (i == S + 1)) begin failures++; $display("FAIL go_pc_en cyc=%0d got=%b exp=%b", i, pc_en, i == S + 1); end
            checks++; if (halted !== (i != S + 2)) begin failures++; $display("FAIL go_halted cyc=%0d got=%b exp=%b", i, halted, i != S + 2); end
            next();
        end
        @(negedge clk);
        checks++; if (halt_cnt !== 16'd2) begin failures++; $display("FAIL go_halt_cnt got=%0d exp=2", halt_cnt); end
        next();
        release_pause();
    endtask

    task automatic test_exit();
        syscall = 1'b1; v0 = 32'd10;
        @(negedge clk);
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL exit_pc_en0 got=%b exp=0", pc_en); end
        next();
        syscall = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0 && i < 24) go = ~go;
            @(negedge clk);
            checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL exit_pc_en cyc=%0d got=%b exp=0", i, pc_en); end
            checks++; if (exited !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL exit_flags cyc=%0d got=%b%b exp=11", i, exited, halted); end
            next();
        end
        @(negedge clk);
        checks++; if (halt_cnt !== 16'd3) begin failures++; $display("FAIL exit_halt_cnt got=%0d exp=3", halt_cnt); end
        next();
        go = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL exit_rst_pc_en got=%b exp=1", pc_en); end
        next();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (exited !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL exit_after_rst got=%b%b exp=00", exited, halted); end
        checks++; if (halt_cnt !== 16'd0) begin failures++; $display("FAIL exit_rst_halt_cnt got=%0d exp=0", halt_cnt); end
        checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL exit_rst_run got=%b exp=1", pc_en); end
        next();
    endtask

    task automatic test_go_in_run();
        syscall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            go = (i < 4);
            @(negedge clk);
            checks++; if (pc_en !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL run_go cyc=%0d got pc_en=%b halted=%b exp 1/0", i, pc_en, halted); end
            next();
        end
        syscall = 1'b1; v0 = 32'h00000122; a0 = 32'h12345678;
        @(negedge clk);
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL near_print_pc_en got=%b exp=0", pc_en); end
        next();
        syscall = 1'b0;
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL near_print_halted got=%b exp=1", halted); end
        checks++; if (print_cnt !== 16'd0 || disp_valid !== 1'b0) begin failures++; $display("FAIL near_print_cnt got=%0d/%b exp=0/0", print_cnt, disp_valid); end
        checks++; if (halt_cnt !== 16'd1) begin failures++; $display("FAIL near_print_halt_cnt got=%0d exp=1", halt_cnt); end
        next();
        release_pause();
    endtask

    task automatic test_saturation();
        logic [15:0] exp_cnt;
        syscall = 1'b1; v0 = 32'd34;
        for (int i = 0; i < 65537; i++) begin
            a0 = i;
            exp_q.push_back(a0);
            exp_cnt = (i > 65535) ? 16'hFFFF : 16'(i);
            @(negedge clk);
            checks++; if (print_cnt !== exp_cnt) begin failures++; $display("FAIL sat_print_cnt i=%0d got=%h exp=%h", i, print_cnt, exp_cnt); end
            next();
        end
        v0 = 32'd7; rst = 1'b1;
        @(negedge clk);
        checks++; if (print_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_final got=%h exp=ffff", print_cnt); end
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL rst_syscall_pc_en got=%b exp=0", pc_en); end
        next();
        rst = 1'b0; syscall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (halted !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL rst_priority cyc=%0d got halted=%b pc_en=%b exp 0/1", i, halted, pc_en); end
            checks++; if (halt_cnt !== 16'd0 || print_cnt !== 16'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", halt_cnt, print_cnt); end
            next();
        end
    endtask

    initial begin
        rst = 1'b1; syscall = 1'b0; go = 1'b0; v0 = '0; a0 = '0;
        #1;
        test_reset();
        test_print();
        test_pause();
        test_exit();
        test_go_in_run();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_prints: got=%0d outstanding exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
